// File: rtl/signal_arbiter_if.sv
// Requester/downstream bundle for signal_arbiter.
// master is the arbiter's side; slave is the requesters plus the downstream consumer.
interface signal_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_ready;
  logic [IDX_W-1:0]          grant_id;
  logic                      busy;
  logic                      timeout;

  modport master (
    input  req_valid, req_data, out_ready,
    output req_ack, out_valid, out_data, grant_id, busy, timeout
  );

  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ack, out_valid, out_data, grant_id, busy, timeout
  );
endinterface

// File: rtl/signal_arbiter.sv
// Round-robin arbiter: captures one requester's word into an output register and holds it
// until downstream accepts. Define ARB_TIMEOUT_EN to drop words stalled for TIMEOUT cycles.
module signal_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  signal_arbiter_if.master bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("signal_arbiter: unsupported NUM_REQ/TIMEOUT");
  end

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic [NUM_REQ-1:0] ack;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Search starts just above the last captured requester and wraps.
  always_comb begin
    int unsigned      idx;
    logic [IDX_W-1:0] cand;
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last_grant_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!any_req && bus.req_valid[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    out_data_d   = out_data_q;
    ack          = '0;
`ifdef ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          ack[winner]  = 1'b1;
          out_data_d   = bus.req_data[winner*DATA_W +: DATA_W];
          grant_id_d   = winner;
          last_grant_d = winner;
          state_d      = StHold;
`ifdef ARB_TIMEOUT_EN
          wait_cnt_d   = '0;
`endif
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          state_d = StIdle;
`ifdef ARB_TIMEOUT_EN
        // The stall that brings the count to TIMEOUT drops the word.
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      out_data_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      out_data_q   <= out_data_d;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  // Ack is combinational, so it must also be masked while reset is held.
  assign bus.req_ack   = rst ? '0 : ack;
  assign bus.out_valid = (state_q == StHold);
  assign bus.busy      = (state_q == StHold);
  assign bus.out_data  = out_data_q;
  assign bus.grant_id  = grant_id_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_signal_arbiter.sv
// Bench for signal_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_signal_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  signal_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  signal_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = $urandom();
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    bus.req_data  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.req_valid = 4'b1111;
    randomize_data();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 32'h0 ||
        bus.grant_id !== 2'd0 || bus.timeout !== 1'b0 || bus.req_ack !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async: valid=%b busy=%b data=%h gid=%0d to=%b ack=%b want all 0",
               bus.out_valid, bus.busy, bus.out_data, bus.grant_id, bus.timeout, bus.req_ack);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (bus.req_ack !== 4'b0000 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: ack=%b valid=%b want 0000/0", bus.req_ack, bus.out_valid);
    end
    bus.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    randomize_data();
    bus.req_valid = 4'b0100;
    bus.req_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.req_ack !== 4'b0100 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ack: ack=%b valid=%b want 0100/0", bus.req_ack, bus.out_valid);
    end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEADBEEF || bus.grant_id !== 2'd2 ||
        bus.req_ack !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_out: valid=%b data=%h gid=%0d ack=%b want 1/DEADBEEF/2/0000",
               bus.out_valid, bus.out_data, bus.grant_id, bus.req_ack);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: valid=%b busy=%b want 0/0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_ack;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = 32'hA000_0000 + i;
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_ack = '0;
      if (c % 2 == 0) exp_ack[(c / 2) % NUM_REQ] = 1'b1;
      vectors++;
      if (bus.req_ack !== exp_ack || bus.out_valid !== logic'(c % 2)) begin
        miscompares++;
        $display("FAIL rr_ack c%0d: ack=%b valid=%b want %b/%0d",
                 c, bus.req_ack, bus.out_valid, exp_ack, c % 2);
      end
      if (c % 2 == 1) begin
        vectors++;
        if (bus.grant_id !== 2'((c / 2) % NUM_REQ) ||
            bus.out_data !== 32'hA000_0000 + (c / 2) % NUM_REQ) begin
          miscompares++;
          $display("FAIL rr_grant c%0d: gid=%0d data=%h want %0d", c, bus.grant_id,
                   bus.out_data, (c / 2) % NUM_REQ);
        end
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] word;
    do_reset();
    randomize_data();
    word = bus.req_data[1*DATA_W +: DATA_W];
    bus.req_valid = 4'b0010;
    @(negedge clk);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) bus.out_ready = 1'b1;
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== word || bus.grant_id !== 2'd1 ||
          bus.req_ack !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_hold c%0d: valid=%b data=%h gid=%0d ack=%b want 1/%h/1/0000",
                 c, bus.out_valid, bus.out_data, bus.grant_id, bus.req_ack, word);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.req_ack !== 4'b0100) begin
      miscompares++;
      $display("FAIL bp_done: valid=%b ack=%b want 0/0100", bus.out_valid, bus.req_ack);
    end
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    do_reset();
    randomize_data();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.grant_id !== 2'd2) begin
      miscompares++;
      $display("FAIL midrst_pre: valid=%b gid=%0d want 1/2", bus.out_valid, bus.grant_id);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_drop: valid=%b want 0", bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'b0101;
    #1;
    vectors++;
    if (bus.req_ack !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_prio: ack=%b want 0001", bus.req_ack);
    end
    @(negedge clk);
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    randomize_data();
    for (int run = 0; run < 2; run++) begin
      bus.req_valid = 4'b0001;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = '0;
      for (int c = 0; c < TIMEOUT; c++) begin
        if (run == 1 && c == TIMEOUT - 1) bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.timeout !== 1'b0) begin
          miscompares++;
          $display("FAIL to_wait r%0d c%0d: valid=%b to=%b want 1/0", run, c, bus.out_valid,
                   bus.timeout);
        end
        @(negedge clk);
      end
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.timeout !== logic'(run == 0)) begin
        miscompares++;
        $display("FAIL to_end r%0d: valid=%b to=%b want 0/%0d", run, bus.out_valid,
                 bus.timeout, run == 0);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (bus.timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL to_pulse r%0d: to=%b want 0", run, bus.timeout);
      end
    end
  endtask
`endif

  // Model tracks transactions only: whether a word is held, whose, and what it contains.
  task automatic test_random();
    int                 m_last = NUM_REQ - 1;
    bit                 m_held = 1'b0;
    int                 m_id   = 0;
    logic [DATA_W-1:0]  m_data = '0;
    int                 m_wait = 0;
    bit                 m_to_now = 1'b0;
    bit                 m_to_next;
    int                 pick;
    logic [NUM_REQ-1:0] exp_ack;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      randomize_data();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      pick    = rr_pick(m_last, bus.req_valid);
      exp_ack = '0;
      if (!m_held && pick >= 0) exp_ack[pick] = 1'b1;
      vectors++;
      if (bus.req_ack !== exp_ack || bus.out_valid !== m_held || bus.busy !== m_held ||
          bus.timeout !== m_to_now) begin
        miscompares++;
        $display("FAIL rand_ctl c%0d: ack=%b valid=%b busy=%b to=%b want %b/%b/%b/%b", c,
                 bus.req_ack, bus.out_valid, bus.busy, bus.timeout, exp_ack, m_held, m_held,
                 m_to_now);
      end
      if (m_held) begin
        vectors++;
        if (bus.out_data !== m_data || bus.grant_id !== 2'(m_id)) begin
          miscompares++;
          $display("FAIL rand_data c%0d: data=%h gid=%0d want %h/%0d", c, bus.out_data,
                   bus.grant_id, m_data, m_id);
        end
      end
      m_to_next = 1'b0;
      if (m_held) begin
        if (bus.out_ready) m_held = 1'b0;
`ifdef ARB_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_held    = 1'b0;
            m_to_next = 1'b1;
          end
        end
`endif
      end else if (pick >= 0) begin
        m_held = 1'b1;
        m_id   = pick;
        m_last = pick;
        m_data = bus.req_data[pick*DATA_W +: DATA_W];
        m_wait = 0;
      end
      m_to_now = m_to_next;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
